gon: RTL
========

Name: gon

Overview:
- Global Output Network: the gather-direction counterpart of the ifmap multicast network.
- The top-level controller requests one psum by (row_tag, col_tag).
- gon selects the single PE whose scanned-in row ID and column ID match, pulls that PE's opsum over its data+valid/ready port, and returns it to the controller through a valid/ready output.
- It sits between the PE array (XBUS_NUMS x PE_NUMS PEWrappers) and the psum/global buffer.

Parameters:
- XBUS_NUMS, 12, number of Y-buses (rows of PEs)
- PE_NUMS, 14, PEs per Y-bus
- ID_LEN, 5, column-ID/col_tag width
- ROW_LEN, 4, row-ID/row_tag width
- PSUM_WIDTH, 32, psum data width

Ports:
- clk  in  1  clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  psum request valid
- req_ready  out  1  gon can accept a request
- row_tag  in  ROW_LEN  requested row tag
- col_tag  in  ID_LEN  requested column tag
- out_valid  out  1  out_data/out_miss valid
- out_ready  in  1  consumer accepts output
- out_data  out  PSUM_WIDTH  returned psum
- out_miss  out  1  no PE matched the request
- set_row  in  1  shift row-ID chain
- row_scan_in  in  ROW_LEN  row-ID chain input
- row_scan_out  out  ROW_LEN  row-ID chain output
- set_id  in  1  shift col-ID chain
- id_scan_in  in  ID_LEN  col-ID chain input
- id_scan_out  out  ID_LEN  col-ID chain output
- pe_opsum  in  (PSUM_WIDTH+1)*XBUS_NUMS*PE_NUMS  per PE {valid, data}; valid is the MSB; PE k = i*PE_NUMS+j occupies slice k
- pe_opsum_ready  out  XBUS_NUMS*PE_NUMS  per-PE ready

Behaviour:
- Reset values:
  - All row IDs and col IDs are 0.
  - State is IDLE.
  - req_ready = 0 during the reset cycle, then 1.
  - out_valid = 0, out_data = 0, out_miss = 0, pe_opsum_ready = 0.
  - A reset mid-transaction abandons it; no PE handshake completes after rst.
- Scan chains:
  - On set_row: row_id[0] <= row_scan_in and row_id[k] <= row_id[k-1]. row_scan_out = row_id[XBUS_NUMS-1].
  - The col-ID chain works the same way over XBUS_NUMS*PE_NUMS entries on set_id.
  - After N shifts, the first-scanned value sits at the highest index.
  - Shifts take effect only in IDLE; set_row/set_id are ignored in other states.
  - Both chains may shift in the same cycle.
- FSM states: IDLE, MATCH, PULL, OUTPUT.
  - IDLE: req_ready = 1. When req_valid && req_ready, latch the tags and go to MATCH.
  - MATCH (1 cycle): register the selected index. The selected PE is the lowest flattened k with row_id[k/PE_NUMS] == tag_r and col_id[k] == tag_c.
    - Match found: go to PULL.
    - No match: set out_miss = 1, out_data = 0, and go to OUTPUT.
  - PULL: pe_opsum_ready[sel] = 1; all other ready bits are 0.
    - The transfer happens on an edge where the selected PE's valid bit and ready are both 1.
    - On that edge: capture the data into out_data, set out_miss = 0, drop ready, and go to OUTPUT.
    - PULL waits indefinitely for valid.
  - OUTPUT: out_valid = 1 and out_data is held stable until out_ready. On out_valid && out_ready, clear out_valid and go to IDLE.
- Latency:
  - If the PE is already valid, the accept edge is t0 and out_valid is high after edge t2 (3 cycles from accept to consumable).
  - The minimum request-to-request spacing with out_ready tied high is 4 cycles.
- Invariants:
  - At most one pe_opsum_ready bit is high at any time.
  - A PE valid bit while that PE's ready is 0 has no effect.
  - Duplicate matches resolve by lowest index and are not flagged.
  - Tags are compared at full width with no wildcard.

Decomposition:
- Package gon_pkg holds:
  - state enum {IDLE, MATCH, PULL, OUTPUT}
  - localparam TOTAL_PE = XBUS_NUMS*PE_NUMS
  - SEL_W = $clog2(TOTAL_PE)
- Sub-module gon_tag_match: combinational match vector plus lowest-index priority encoder. It outputs {hit, sel_idx}.
- Scan chains and the FSM stay in gon.

Test Plan:
- Reset, then scan row IDs 0..11 (first-scanned lands at xbus 11) and col IDs so PE k has id k%30. Read back row_scan_out over 12 set_row shifts -> the scanned sequence returns in order.
- Config row_id[1]=0, PE k=16 col_id=16, PE 16 drives valid with 0xDEADBEEF. Request (row 0, col 16) -> pe_opsum_ready[16] only, out_valid 3 cycles after accept, out_data = 0xDEADBEEF, out_miss = 0.
- Request (row 15, col 31) with no matching PE -> out_valid after 2 cycles, out_miss = 1, out_data = 0, no pe_opsum_ready asserted.
- PE valid delayed 10 cycles with out_ready held low 5 cycles after out_valid -> ready held through the wait; out_data stays stable; req_ready = 0 until the output handshake, then 1 the next cycle.
- Two PEs (k=20, k=40) both match -> k=20 is pulled; PE 40 ready stays 0.
- Assert rst in PULL; assert set_id in PULL -> next cycle all outputs are at their reset values; IDs are unchanged by the set_id pulse issued in PULL.

Source files
------------

// File: rtl/gon_pkg.sv
// gon_pkg: shared sizes, FSM state type and bus payload types for the
// Global Output Network (psum gather from the PE array).
package gon_pkg;

    localparam int unsigned XBUS_NUMS  = 12;
    localparam int unsigned PE_NUMS    = 14;
    localparam int unsigned ID_LEN     = 5;
    localparam int unsigned ROW_LEN    = 4;
    localparam int unsigned PSUM_WIDTH = 32;
    localparam int unsigned TOTAL_PE   = XBUS_NUMS * PE_NUMS;
    localparam int unsigned SEL_W      = $clog2(TOTAL_PE);

    typedef enum logic [1:0] {
        IDLE,
        MATCH,
        PULL,
        OUTPUT
    } state_e;

    // One PE output port: valid is the MSB, data below it.
    typedef struct packed {
        logic                  valid;
        logic [PSUM_WIDTH-1:0] data;
    } opsum_t;

    typedef logic [XBUS_NUMS-1:0][ROW_LEN-1:0] row_ids_t;
    typedef logic [TOTAL_PE-1:0][ID_LEN-1:0]   col_ids_t;

endpackage

// File: rtl/gon_if.sv
// gon_if: controller-facing request/response handshake of gon.
//   req_valid/req_ready/row_tag/col_tag : psum request
//   out_valid/out_ready/out_data/out_miss : psum response
// master = controller side, slave = gon side.
interface gon_if;
    import gon_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [ROW_LEN-1:0]    row_tag;
    logic [ID_LEN-1:0]     col_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [PSUM_WIDTH-1:0] out_data;
    logic                  out_miss;

    modport master (
        output req_valid, row_tag, col_tag, out_ready,
        input  req_ready, out_valid, out_data, out_miss
    );

    modport slave (
        input  req_valid, row_tag, col_tag, out_ready,
        output req_ready, out_valid, out_data, out_miss
    );

endinterface

// File: rtl/gon_tag_match.sv
// gon_tag_match: combinational tag compare over every PE and a
// lowest-index priority encoder.
//   row_id/col_id : scanned-in IDs
//   tag_r/tag_c   : requested tags
//   hit_c         : at least one PE matches
//   sel_idx_c     : lowest flattened index that matches (0 when no hit)
module gon_tag_match
    import gon_pkg::*;
(
    input  row_ids_t           row_id,
    input  col_ids_t           col_id,
    input  logic [ROW_LEN-1:0] tag_r,
    input  logic [ID_LEN-1:0]  tag_c,
    output logic               hit_c,
    output logic [SEL_W-1:0]   sel_idx_c
);

    logic [TOTAL_PE-1:0] match;

    // PE k = i*PE_NUMS + j shares its row ID with the rest of Y-bus i.
    for (genvar i = 0; i < int'(XBUS_NUMS); i++) begin : g_row
        for (genvar j = 0; j < int'(PE_NUMS); j++) begin : g_pe
            assign match[i*PE_NUMS+j] = (row_id[i] == tag_r) &&
                                        (col_id[i*PE_NUMS+j] == tag_c);
        end
    end

    // Scan from the top down so the lowest matching index wins.
    always_comb begin
        hit_c     = |match;
        sel_idx_c = '0;
        for (int k = int'(TOTAL_PE) - 1; k >= 0; k--) begin
            if (match[SEL_W'(k)]) begin
                sel_idx_c = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/gon.sv
// gon: Global Output Network. Accepts a (row_tag, col_tag) request,
// locates the matching PE, pulls its opsum and returns it (or a miss).
//   clk, rst         : clock, synchronous active-high reset
//   bus              : request/response handshake (gon_if.slave)
//   set_row/row_scan_in/row_scan_out : row-ID scan chain (XBUS_NUMS deep)
//   set_id/id_scan_in/id_scan_out    : col-ID scan chain (TOTAL_PE deep)
//   pe_opsum         : per-PE {valid, data}
//   pe_opsum_ready   : per-PE ready, at most one bit high
module gon
    import gon_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    gon_if.slave                      bus,
    input  logic                      set_row,
    input  logic [ROW_LEN-1:0]        row_scan_in,
    output logic [ROW_LEN-1:0]        row_scan_out,
    input  logic                      set_id,
    input  logic [ID_LEN-1:0]         id_scan_in,
    output logic [ID_LEN-1:0]         id_scan_out,
    input  opsum_t [TOTAL_PE-1:0]     pe_opsum,
    output logic [TOTAL_PE-1:0]       pe_opsum_ready
);

    state_e                state, state_d;
    row_ids_t              row_id;
    col_ids_t              col_id;
    logic [ROW_LEN-1:0]    row_tag_r, row_tag_d;
    logic [ID_LEN-1:0]     col_tag_r, col_tag_d;
    logic [SEL_W-1:0]      sel_r, sel_d;
    logic                  req_ready_r, req_ready_d;
    logic                  out_valid_r, out_valid_d;
    logic [PSUM_WIDTH-1:0] out_data_r, out_data_d;
    logic                  out_miss_r, out_miss_d;
    logic [TOTAL_PE-1:0]   pe_ready_r, pe_ready_d;
    logic                  hit_c;
    logic [SEL_W-1:0]      sel_idx_c;

    assign bus.req_ready  = req_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_data   = out_data_r;
    assign bus.out_miss   = out_miss_r;
    assign pe_opsum_ready = pe_ready_r;
    assign row_scan_out   = row_id[XBUS_NUMS-1];
    assign id_scan_out    = col_id[TOTAL_PE-1];

    gon_tag_match u_match (
        .row_id    (row_id),
        .col_id    (col_id),
        .tag_r     (row_tag_r),
        .tag_c     (col_tag_r),
        .hit_c     (hit_c),
        .sel_idx_c (sel_idx_c)
    );

    // ID scan chains; frozen outside IDLE so a pending match stays valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_id <= '0;
            col_id <= '0;
        end else if (state == IDLE) begin
            if (set_row) begin
                row_id <= {row_id[XBUS_NUMS-2:0], row_scan_in};
            end
            if (set_id) begin
                col_id <= {col_id[TOTAL_PE-2:0], id_scan_in};
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            row_tag_r   <= '0;
            col_tag_r   <= '0;
            sel_r       <= '0;
            req_ready_r <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_miss_r  <= 1'b0;
            pe_ready_r  <= '0;
        end else begin
            state       <= state_d;
            row_tag_r   <= row_tag_d;
            col_tag_r   <= col_tag_d;
            sel_r       <= sel_d;
            req_ready_r <= req_ready_d;
            out_valid_r <= out_valid_d;
            out_data_r  <= out_data_d;
            out_miss_r  <= out_miss_d;
            pe_ready_r  <= pe_ready_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        row_tag_d   = row_tag_r;
        col_tag_d   = col_tag_r;
        sel_d       = sel_r;
        req_ready_d = req_ready_r;
        out_valid_d = out_valid_r;
        out_data_d  = out_data_r;
        out_miss_d  = out_miss_r;
        pe_ready_d  = pe_ready_r;

        case (state)
            IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid && req_ready_r) begin
                    row_tag_d   = bus.row_tag;
                    col_tag_d   = bus.col_tag;
                    req_ready_d = 1'b0;
                    state_d     = MATCH;
                end
            end
            MATCH: begin
                if (hit_c) begin
                    sel_d                 = sel_idx_c;
                    pe_ready_d            = '0;
                    pe_ready_d[sel_idx_c] = 1'b1;
                    state_d               = PULL;
                end else begin
                    out_miss_d  = 1'b1;
                    out_data_d  = '0;
                    out_valid_d = 1'b1;
                    state_d     = OUTPUT;
                end
            end
            PULL: begin
                // Only the selected ready bit is high, so its valid alone
                // decides the transfer edge.
                if (pe_opsum[sel_r].valid) begin
                    out_data_d  = pe_opsum[sel_r].data;
                    out_miss_d  = 1'b0;
                    out_valid_d = 1'b1;
                    pe_ready_d  = '0;
                    state_d     = OUTPUT;
                end
            end
            OUTPUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
